// File: rtl/tone_pkg.sv
// Shared constants for the piano tone synthesiser: note indices, octave-1 half-period
// table and FSM state encoding.
package tone_pkg;

  localparam int TONE_W = 16;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  // Half-periods of octave 1 in 1 MHz cycles; higher octaves are right shifts.
  localparam logic [TONE_W-1:0] BASE_HALF_C = 16'd15289;
  localparam logic [TONE_W-1:0] BASE_HALF_D = 16'd13621;
  localparam logic [TONE_W-1:0] BASE_HALF_E = 16'd12135;
  localparam logic [TONE_W-1:0] BASE_HALF_F = 16'd11454;
  localparam logic [TONE_W-1:0] BASE_HALF_G = 16'd10204;
  localparam logic [TONE_W-1:0] BASE_HALF_A = 16'd9091;
  localparam logic [TONE_W-1:0] BASE_HALF_B = 16'd8099;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  function automatic logic [TONE_W-1:0] base_half(input logic [2:0] n);
    logic [TONE_W-1:0] h;
    h = '0;
    case (n)
      NOTE_C:  h = BASE_HALF_C;
      NOTE_D:  h = BASE_HALF_D;
      NOTE_E:  h = BASE_HALF_E;
      NOTE_F:  h = BASE_HALF_F;
      NOTE_G:  h = BASE_HALF_G;
      NOTE_A:  h = BASE_HALF_A;
      NOTE_B:  h = BASE_HALF_B;
      default: h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: holds the half-period, counts phase and toggles AIN.
// A load restarts the phase with AIN high on the same edge.
module tone_divider
  import tone_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_1M,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] half_in,
  output logic             ain
);

  logic [CNT_W-1:0] half_reg;
  logic [CNT_W-1:0] ph_cnt_reg;
  logic             ain_reg;
  logic             wrap;

  assign wrap = (ph_cnt_reg == half_reg - CNT_W'(1));

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      half_reg   <= '0;
      ph_cnt_reg <= '0;
      ain_reg    <= 1'b0;
    end else if (load) begin
      half_reg   <= half_in;
      ph_cnt_reg <= '0;
      ain_reg    <= 1'b1;
    end else if (clear) begin
      ph_cnt_reg <= '0;
      ain_reg    <= 1'b0;
    end else if (enable) begin
      if (wrap) begin
        ph_cnt_reg <= '0;
        ain_reg    <= ~ain_reg;
      end else begin
        ph_cnt_reg <= ph_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign ain = ain_reg;

endmodule

// File: rtl/tone_synth.sv
// PmodAMP2 driver: registers the played key, detects changes, and sequences
// IDLE / PLAY / RELEASE around a square-wave divider.
module tone_synth
  import tone_pkg::*;
#(
  parameter bit GAIN_SEL       = 1'b1,
  parameter int RELEASE_CYCLES = 20000,
  parameter int CNT_W          = 16
) (
  input  logic       clk_1M,
  input  logic       rst,
  input  logic [2:0] octave,
  input  logic [2:0] note,
  output logic       AIN,
  output logic       GAIN,
  output logic       NC,
  output logic       ACTIVE,
  output logic       tone_on
);

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  logic [5:0]       key_reg;
  logic [5:0]       key_prev_reg;
  logic [1:0]       state_reg, state_next;
  logic [REL_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic             key_valid;
  logic             key_change;
  logic             rel_done;
  logic             load;
  logic             clear;
  logic             enable;
  logic [CNT_W-1:0] half_next;
  logic [TONE_W-1:0] half_raw;

  assign key_valid  = (key_reg[5:3] != 3'd0) && (key_reg[2:0] != NOTE_REST);
  assign key_change = (key_reg != key_prev_reg);
  assign rel_done   = (rel_cnt_reg == REL_W'(RELEASE_CYCLES - 1));

  // Octave 0 never reaches the shifter as a valid key, so its shift amount is don't-care.
  assign half_raw  = base_half(key_reg[2:0]) >> (key_reg[5:3] - 3'd1);
  assign half_next = CNT_W'(half_raw);

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      key_reg      <= '0;
      key_prev_reg <= '0;
      state_reg    <= ST_IDLE;
      rel_cnt_reg  <= '0;
    end else begin
      key_reg      <= {octave, note};
      key_prev_reg <= key_reg;
      state_reg    <= state_next;
      rel_cnt_reg  <= rel_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rel_cnt_next = rel_cnt_reg;
    load         = 1'b0;
    clear        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (key_change && key_valid) begin
          state_next = ST_PLAY;
          load       = 1'b1;
        end
      end
      ST_PLAY: begin
        if (key_change) begin
          if (key_valid) begin
            load = 1'b1;
          end else begin
            state_next   = ST_RELEASE;
            rel_cnt_next = '0;
          end
        end
      end
      ST_RELEASE: begin
        // A new note beats tail expiry when both land on the same edge.
        if (key_change && key_valid) begin
          state_next = ST_PLAY;
          load       = 1'b1;
        end else if (rel_done) begin
          state_next   = ST_IDLE;
          clear        = 1'b1;
          rel_cnt_next = '0;
        end else begin
          rel_cnt_next = rel_cnt_reg + REL_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        clear      = 1'b1;
      end
    endcase
  end

  assign enable = (state_reg != ST_IDLE);

  tone_divider #(
    .CNT_W(CNT_W)
  ) u_divider (
    .clk_1M (clk_1M),
    .rst    (rst),
    .load   (load),
    .enable (enable),
    .clear  (clear),
    .half_in(half_next),
    .ain    (AIN)
  );

  assign ACTIVE  = (state_reg != ST_IDLE);
  assign tone_on = (state_reg == ST_PLAY);
  assign GAIN    = GAIN_SEL;
  assign NC      = 1'b0;

endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth: stimulus pushes expected {AIN,ACTIVE,tone_on}
// change events with their cycle; a negedge monitor pops one per observed change.
module tb_tone_synth;

  localparam int RC = 20000;
  localparam int M_IDLE = 0, M_PLAY = 1, M_REL = 2;

  logic       clk_1M = 1'b0;
  logic       rst;
  logic [2:0] octave, note;
  logic       AIN, GAIN, NC, ACTIVE, tone_on;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] prev_obs = 3'b000;
  logic [2:0] last_push = 3'b000;
  bit         mon_en = 1'b0;

  int         mode = M_IDLE;
  int         tone_s, tone_h, rel_s;
  logic [5:0] last_key = '0;

  tone_synth dut (
    .clk_1M (clk_1M),
    .rst    (rst),
    .octave (octave),
    .note   (note),
    .AIN    (AIN),
    .GAIN   (GAIN),
    .NC     (NC),
    .ACTIVE (ACTIVE),
    .tone_on(tone_on)
  );

  always #5 clk_1M = ~clk_1M;
  always @(posedge clk_1M) cyc <= cyc + 1;

  // Monitor: every visible change of the output triple is one transaction.
  always @(negedge clk_1M) begin
    logic [2:0] cur;
    ev_t        e;
    cur = {AIN, ACTIVE, tone_on};
    if (mon_en && cur !== prev_obs) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cycle %0d got %b required no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.val !== cur) begin
          errors++;
          $display("FAIL out_event got cycle %0d val %b required cycle %0d val %b",
                   cyc, cur, e.cyc, e.val);
        end else begin
          $display("event cycle %0d AIN/ACTIVE/tone_on=%b ok", cyc, cur);
        end
      end
    end
    prev_obs = cur;
  end

  task automatic push_ev(input int c, input logic [2:0] v);
    if (v !== last_push) begin
      q.push_back('{cyc: c, val: v});
      last_push = v;
    end
  endtask

  // Expected outputs for edges c0..c1-1 given the planned mode.
  task automatic fill(input int c0, input int c1);
    logic lvl;
    for (int c = c0; c < c1; c++) begin
      lvl = (((c - tone_s) / tone_h) % 2) == 0;
      if (mode == M_PLAY) push_ev(c, {lvl, 2'b11});
      else if (mode == M_REL && c < rel_s + RC) push_ev(c, {lvl, 2'b10});
      else begin
        mode = M_IDLE;
        push_ev(c, 3'b000);
      end
    end
  endtask

  // Drive a key at this negedge, hold it for 'hold' cycles; h is the hand-computed half-period.
  task automatic step(input logic [2:0] o, input logic [2:0] n, input int hold, input int h);
    int d;
    d = cyc;
    octave = o;
    note   = n;
    if ({o, n} != last_key) begin
      if (o != 0 && n != 0) begin
        mode   = M_PLAY;
        tone_s = d + 2;
        tone_h = h;
      end else if (mode == M_PLAY) begin
        mode  = M_REL;
        rel_s = d + 2;
      end
    end
    last_key = {o, n};
    fill(d + 2, d + 2 + hold);
    $display("step cycle %0d octave %0d note %0d hold %0d", d, o, n, hold);
    repeat (hold) @(negedge clk_1M);
  endtask

  task automatic chk(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end else begin
      $display("check %s = %b ok", name, got);
    end
  endtask

  task automatic do_reset(input int hold);
    int d;
    d = cyc;
    @(negedge clk_1M);
    rst    = 1'b1;
    octave = 3'd0;
    note   = 3'd0;
    mode     = M_IDLE;
    last_key = '0;
    fill(d + 2, d + 2 + hold);
    @(negedge clk_1M);
    rst = 1'b0;
    $display("reset at cycle %0d", cyc);
    chk("rst_AIN", AIN, 1'b0);
    chk("rst_ACTIVE", ACTIVE, 1'b0);
    chk("rst_tone_on", tone_on, 1'b0);
    chk("rst_GAIN", GAIN, 1'b1);
    chk("rst_NC", NC, 1'b0);
    repeat (hold - 2) @(negedge clk_1M);
  endtask

  initial begin
    rst    = 1'b1;
    octave = 3'd0;
    note   = 3'd0;
    repeat (3) @(posedge clk_1M);
    @(negedge clk_1M);
    chk("init_AIN", AIN, 1'b0);
    chk("init_ACTIVE", ACTIVE, 1'b0);
    chk("init_tone_on", tone_on, 1'b0);
    chk("init_GAIN", GAIN, 1'b1);
    chk("init_NC", NC, 1'b0);
    rst = 1'b0;
    prev_obs = {AIN, ACTIVE, tone_on};
    mon_en = 1'b1;

    step(3'd4, 3'd6, 1136 * 8 + 100, 1136);  // A4
    step(3'd4, 3'd1, 1911 * 4 + 37, 1911);   // C4
    step(3'd7, 3'd7, 126 * 10 + 5, 126);     // B7
    step(3'd0, 3'd0, RC + 100, 0);           // full release tail
    step(3'd0, 3'd3, 300, 0);                // octave 0 is a rest
    step(3'd4, 3'd6, 2000, 1136);
    step(3'd4, 3'd6, 3000, 1136);            // same key: phase continuous
    step(3'd0, 3'd0, 1, 0);                  // one-cycle rest
    step(3'd4, 3'd6, 1500, 1136);            // phase restarts
    step(3'd5, 3'd6, 700, 568);              // octave-only retrigger
    step(3'd0, 3'd0, RC, 0);                 // new note lands on expiry edge
    step(3'd2, 3'd3, 500, 6067);             // E2
    step(3'd0, 3'd0, 500, 0);
    do_reset(50);                            // mid-release
    step(3'd1, 3'd1, 3000, 15289);           // C1
    do_reset(50);                            // mid-play
    step(3'd0, 3'd0, 10, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
